// File: rtl/eth_tx_frame_arbiter.sv
// eth_tx_frame_arbiter
//   Frame-granular round-robin arbiter that shares the single 64-bit Ethernet TX
//   AXI-Stream between NumIn requesters. The winner owns the output until its
//   tlast. A frame longer than MaxBeats is cut at beat MaxBeats: that beat goes
//   out with tlast and tuser[0] forced to 1, and the rest of the frame is
//   accepted and dropped.
// Ports
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   in_req_i/in_rsp_o   requester streams and their tready
//   out_req_o/out_rsp_i shared TX stream and its tready
//   en_i                per-input arbitration enable
//   grant_o             one-hot current owner (0 while idle)
//   busy_o              a frame is being forwarded or drained
//   frames_o            completed frames, truncated ones included (wraps)
//   oversize_o          truncated frames (wraps)

package eth_idma_pkg;
  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic [3:0]  user;
  } axi_stream_t;

  typedef struct packed {
    axi_stream_t t;
    logic        tvalid;
  } axi_stream_req_t;

  typedef struct packed {
    logic tready;
  } axi_stream_rsp_t;
endpackage

// Per-input slice: arbitration candidacy and the tready returned to that input.
module eth_tx_arb_lane (
  input  logic tvalid,
  input  logic en,
  input  logic sel,
  input  logic fwd,
  input  logic drain,
  input  logic out_ready,
  output logic cand,
  output logic ready
);
  assign cand  = tvalid & en;
  // The owner follows the output tready while forwarding and is always ready
  // while its oversize tail is being dropped.
  assign ready = sel & ((fwd & out_ready) | drain);
endmodule

module eth_tx_frame_arbiter #(
  parameter int unsigned NumIn    = 2,
  parameter int unsigned MaxBeats = 192,
  parameter int unsigned CntWidth = 32,
  parameter type axi_stream_req_t = eth_idma_pkg::axi_stream_req_t,
  parameter type axi_stream_rsp_t = eth_idma_pkg::axi_stream_rsp_t
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  axi_stream_req_t [NumIn-1:0]       in_req_i,
  output axi_stream_rsp_t [NumIn-1:0]       in_rsp_o,
  output axi_stream_req_t                   out_req_o,
  input  axi_stream_rsp_t                   out_rsp_i,
  input  logic            [NumIn-1:0]       en_i,
  output logic            [NumIn-1:0]       grant_o,
  output logic                              busy_o,
  output logic            [CntWidth-1:0]    frames_o,
  output logic            [CntWidth-1:0]    oversize_o
);
  localparam int unsigned IdxW  = (NumIn > 1) ? $clog2(NumIn) : 1;
  localparam int unsigned BeatW = (MaxBeats > 1) ? $clog2(MaxBeats) : 1;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StFwd   = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [IdxW-1:0]     grant_q, grant_d;
  logic [IdxW-1:0]     rr_q, rr_d;
  logic [BeatW-1:0]    beat_q, beat_d;
  logic [CntWidth-1:0] frames_q, frames_d;
  logic [CntWidth-1:0] over_q, over_d;

  logic [NumIn-1:0]    cand, ready;
  axi_stream_req_t     own_req;
  logic                in_hs, at_limit, truncate, found;
  logic [IdxW-1:0]     pick, grant_next;

  for (genvar i = 0; i < NumIn; i++) begin : g_lane
    eth_tx_arb_lane u_lane (
      .tvalid    (in_req_i[i].tvalid),
      .en        (en_i[i]),
      .sel       (grant_q == IdxW'(i)),
      .fwd       (state_q == StFwd),
      .drain     (state_q == StDrain),
      .out_ready (out_rsp_i.tready),
      .cand      (cand[i]),
      .ready     (ready[i])
    );
  end

  assign own_req    = in_req_i[grant_q];
  assign in_hs      = own_req.tvalid & ready[grant_q];
  assign at_limit   = (beat_q == BeatW'(MaxBeats - 1));
  // Truncation is a function of the held beat only, so the forced fields stay
  // stable while the output is stalled.
  assign truncate   = (state_q == StFwd) & at_limit & ~own_req.t.last;
  assign grant_next = (grant_q == IdxW'(NumIn - 1)) ? '0 : grant_q + 1'b1;

  // Round-robin search starting at rr_q, wrapping modulo NumIn.
  always_comb begin
    int unsigned idx;
    logic [IdxW-1:0] cidx;
    found = 1'b0;
    pick  = rr_q;
    idx   = 0;
    cidx  = '0;
    for (int unsigned k = 0; k < NumIn; k++) begin
      idx  = (32'(rr_q) + k) % NumIn;
      cidx = IdxW'(idx);
      if (!found && cand[cidx]) begin
        found = 1'b1;
        pick  = cidx;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_d     = rr_q;
    beat_d   = beat_q;
    frames_d = frames_q;
    over_d   = over_q;
    case (state_q)
      StIdle: begin
        if (found) begin
          grant_d = pick;
          beat_d  = '0;
          state_d = StFwd;
        end
      end
      StFwd: begin
        if (in_hs) begin
          beat_d = beat_q + 1'b1;
          if (own_req.t.last || at_limit) begin
            frames_d = frames_q + 1'b1;
            rr_d     = grant_next;
            if (own_req.t.last) begin
              state_d = StIdle;
            end else begin
              over_d  = over_q + 1'b1;
              state_d = StDrain;
            end
          end
        end
      end
      StDrain: begin
        if (in_hs && own_req.t.last) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      grant_q  <= '0;
      rr_q     <= '0;
      beat_q   <= '0;
      frames_q <= '0;
      over_q   <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_q     <= rr_d;
      beat_q   <= beat_d;
      frames_q <= frames_d;
      over_q   <= over_d;
    end
  end

  always_comb begin
    out_req_o = '0;
    if (state_q == StFwd) begin
      out_req_o = own_req;
      if (truncate) begin
        out_req_o.t.last    = 1'b1;
        out_req_o.t.user[0] = 1'b1;
      end
    end
  end

  always_comb begin
    in_rsp_o = '0;
    for (int unsigned i = 0; i < NumIn; i++) in_rsp_o[i].tready = ready[i];
  end

  always_comb begin
    grant_o = '0;
    if (state_q != StIdle) grant_o[grant_q] = 1'b1;
  end

  assign busy_o     = (state_q != StIdle);
  assign frames_o   = frames_q;
  assign oversize_o = over_q;

endmodule

// File: tb/tb_eth_tx_frame_arbiter.sv
module tb_eth_tx_frame_arbiter;
  import eth_idma_pkg::*;

  localparam int NIN  = 2;
  localparam int MAXB = 4;

  logic                     clk = 1'b0;
  logic                     rst_n;
  axi_stream_req_t [NIN-1:0] in_req;
  axi_stream_rsp_t [NIN-1:0] in_rsp;
  axi_stream_req_t          out_req;
  axi_stream_rsp_t          out_rsp;
  logic [NIN-1:0]           en;
  logic [NIN-1:0]           grant;
  logic                     busy;
  logic [31:0]              frames, oversize;

  always #5 clk = ~clk;

  eth_tx_frame_arbiter #(.NumIn(NIN), .MaxBeats(MAXB), .CntWidth(32)) dut (
    .clk_i(clk), .rst_ni(rst_n), .in_req_i(in_req), .in_rsp_o(in_rsp),
    .out_req_o(out_req), .out_rsp_i(out_rsp), .en_i(en), .grant_o(grant),
    .busy_o(busy), .frames_o(frames), .oversize_o(oversize)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model state ----------------
  axi_stream_t src_q[NIN][$];   // beats each input will offer
  axi_stream_t exp_q[NIN][$];   // beats expected on the output per owner
  int          own_log[$];      // owner of each output frame, in order
  int          rr_next;
  bit          pend;
  int          pend_idx;
  bit          in_frm;

  function automatic void add_frame(input int i, input int len, input int tag);
    axi_stream_t b;
    int n;
    n = (len > MAXB) ? MAXB : len;
    for (int k = 0; k < len; k++) begin
      b.data = {8'(i), 8'(tag), 16'(k), 32'($urandom())};
      b.keep = 8'($urandom_range(1, 255));
      b.user = 4'($urandom());
      b.last = (k == len - 1);
      src_q[i].push_back(b);
      if (k < n) begin
        b.last = (k == n - 1);
        if (len > MAXB && k == n - 1) b.user[0] = 1'b1;
        exp_q[i].push_back(b);
      end
    end
  endfunction

  function automatic axi_stream_t mkbeat(input logic [7:0] d, input logic l);
    axi_stream_t b;
    b.data = 64'(d);
    b.keep = 8'hFF;
    b.last = l;
    b.user = 4'h0;
    return b;
  endfunction

  task automatic do_reset();
    rst_n   = 1'b0;
    in_req  = '0;
    out_rsp = '0;
    en      = '1;
    rr_next = 0;
    pend    = 0;
    in_frm  = 0;
    own_log.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Drives queued beats with random valid/ready and checks the output against
  // the per-input expectation queues and the round-robin rule. Entered and
  // left at posedge+1.
  task automatic run_traffic(input int vpct, input int rpct, input int bound);
    bit hs[NIN];
    bit done;
    int cyc;
    int o;
    logic [NIN-1:0] cands;
    axi_stream_t e;
    done = 0;
    cyc  = 0;
    for (int i = 0; i < NIN; i++) hs[i] = 0;
    while (!done) begin
      for (int i = 0; i < NIN; i++) begin
        if (!(in_req[i].tvalid && !hs[i])) begin
          if (src_q[i].size() > 0 && $urandom_range(99) < vpct) begin
            in_req[i].tvalid = 1'b1;
            in_req[i].t      = src_q[i][0];
          end else begin
            in_req[i] = '0;
          end
        end
      end
      out_rsp.tready = ($urandom_range(99) < rpct);
      @(negedge clk);
      if (pend) begin
        check("rr_grant", 128'(grant), 128'(1 << pend_idx));
        rr_next = (pend_idx + 1) % NIN;
        pend    = 0;
      end
      if (!busy) begin
        check("idle_quiet", 128'({out_req.tvalid, in_rsp, grant}), 128'(0));
        for (int i = 0; i < NIN; i++) cands[i] = in_req[i].tvalid & en[i];
        for (int k = 0; k < NIN; k++) begin
          int j;
          j = (rr_next + k) % NIN;
          if (!pend && cands[j]) begin
            pend     = 1;
            pend_idx = j;
          end
        end
      end
      if (out_req.tvalid && out_rsp.tready) begin
        o = 0;
        for (int i = 0; i < NIN; i++) if (grant[i]) o = i;
        check("grant_onehot", 128'($countones(grant)), 128'(1));
        if (exp_q[o].size() == 0) begin
          check("unexpected_beat", 128'(o), 128'(NIN));
        end else begin
          e = exp_q[o].pop_front();
          check("out_beat", 128'(out_req.t), 128'(e));
        end
        if (!in_frm) begin
          own_log.push_back(o);
          in_frm = 1;
        end
        if (out_req.t.last) in_frm = 0;
      end
      for (int i = 0; i < NIN; i++) begin
        hs[i] = in_req[i].tvalid && in_rsp[i].tready;
        if (hs[i]) void'(src_q[i].pop_front());
      end
      done = !busy;
      for (int i = 0; i < NIN; i++) if (src_q[i].size() != 0) done = 0;
      cyc++;
      if (!done && cyc >= bound) begin
        check("traffic_timeout", 128'(cyc), 128'(0));
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    in_req  = '0;
    out_rsp = '0;
  endtask

  // ---------------- directed cycle table ----------------
  typedef struct {
    bit v0, l0; logic [7:0] d0;
    bit v1, l1; logic [7:0] d1;
    logic [1:0] en; bit rdy;
    bit ov, ol, ou; logic [7:0] od; logic [1:0] g; bit busy, r0, r1;
  } vec_t;

  function automatic vec_t mk(bit v0, bit l0, logic [7:0] d0, bit v1, bit l1, logic [7:0] d1,
                              logic [1:0] e, bit rdy, bit ov, bit ol, bit ou, logic [7:0] od,
                              logic [1:0] g, bit b, bit r0, bit r1);
    vec_t v;
    v.v0 = v0; v.l0 = l0; v.d0 = d0; v.v1 = v1; v.l1 = l1; v.d1 = d1;
    v.en = e; v.rdy = rdy; v.ov = ov; v.ol = ol; v.ou = ou; v.od = od;
    v.g = g; v.busy = b; v.r0 = r0; v.r1 = r1;
    return v;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[$];
    logic [15:0] act, expv;
    int nf, nov, len;

    // 3-beat frame on input 0
    tbl.push_back(mk(1,0,8'h10, 0,0,8'h00, 2'b11,1, 0,0,0,8'h00, 2'b00,0,0,0));
    tbl.push_back(mk(1,0,8'h10, 0,0,8'h00, 2'b11,1, 1,0,0,8'h10, 2'b01,1,1,0));
    tbl.push_back(mk(1,0,8'h11, 0,0,8'h00, 2'b11,1, 1,0,0,8'h11, 2'b01,1,1,0));
    tbl.push_back(mk(1,1,8'h12, 0,0,8'h00, 2'b11,1, 1,1,0,8'h12, 2'b01,1,1,0));
    tbl.push_back(mk(0,0,8'h00, 0,0,8'h00, 2'b11,1, 0,0,0,8'h00, 2'b00,0,0,0));
    // enable mask: only input 1 eligible; enable dropped mid-frame
    tbl.push_back(mk(1,0,8'h20, 1,0,8'h30, 2'b10,1, 0,0,0,8'h00, 2'b00,0,0,0));
    tbl.push_back(mk(1,0,8'h20, 1,0,8'h30, 2'b00,1, 1,0,0,8'h30, 2'b10,1,0,1));
    tbl.push_back(mk(1,0,8'h20, 1,1,8'h31, 2'b00,1, 1,1,0,8'h31, 2'b10,1,0,1));
    // 4-beat frame with tready 0101 per beat, last on beat MaxBeats
    tbl.push_back(mk(1,0,8'h20, 0,0,8'h00, 2'b11,1, 0,0,0,8'h00, 2'b00,0,0,0));
    tbl.push_back(mk(1,0,8'h20, 0,0,8'h00, 2'b11,0, 1,0,0,8'h20, 2'b01,1,0,0));
    tbl.push_back(mk(1,0,8'h20, 0,0,8'h00, 2'b11,1, 1,0,0,8'h20, 2'b01,1,1,0));
    tbl.push_back(mk(1,0,8'h21, 0,0,8'h00, 2'b11,0, 1,0,0,8'h21, 2'b01,1,0,0));
    tbl.push_back(mk(1,0,8'h21, 0,0,8'h00, 2'b11,1, 1,0,0,8'h21, 2'b01,1,1,0));
    tbl.push_back(mk(1,0,8'h22, 0,0,8'h00, 2'b11,0, 1,0,0,8'h22, 2'b01,1,0,0));
    tbl.push_back(mk(1,0,8'h22, 0,0,8'h00, 2'b11,1, 1,0,0,8'h22, 2'b01,1,1,0));
    tbl.push_back(mk(1,1,8'h23, 0,0,8'h00, 2'b11,0, 1,1,0,8'h23, 2'b01,1,0,0));
    tbl.push_back(mk(1,1,8'h23, 0,0,8'h00, 2'b11,1, 1,1,0,8'h23, 2'b01,1,1,0));
    // 6-beat frame: truncated at beat 4, beats 5-6 drained, input 1 blocked
    tbl.push_back(mk(1,0,8'h40, 0,0,8'h00, 2'b11,1, 0,0,0,8'h00, 2'b00,0,0,0));
    tbl.push_back(mk(1,0,8'h40, 0,0,8'h00, 2'b11,1, 1,0,0,8'h40, 2'b01,1,1,0));
    tbl.push_back(mk(1,0,8'h41, 0,0,8'h00, 2'b11,1, 1,0,0,8'h41, 2'b01,1,1,0));
    tbl.push_back(mk(1,0,8'h42, 0,0,8'h00, 2'b11,1, 1,0,0,8'h42, 2'b01,1,1,0));
    tbl.push_back(mk(1,0,8'h43, 0,0,8'h00, 2'b11,1, 1,1,1,8'h43, 2'b01,1,1,0));
    tbl.push_back(mk(1,0,8'h44, 1,1,8'h50, 2'b11,1, 0,0,0,8'h00, 2'b01,1,1,0));
    tbl.push_back(mk(1,1,8'h45, 1,1,8'h50, 2'b11,1, 0,0,0,8'h00, 2'b01,1,1,0));
    tbl.push_back(mk(0,0,8'h00, 1,1,8'h50, 2'b11,1, 0,0,0,8'h00, 2'b00,0,0,0));
    tbl.push_back(mk(0,0,8'h00, 1,1,8'h50, 2'b11,1, 1,1,0,8'h50, 2'b10,1,0,1));
    tbl.push_back(mk(0,0,8'h00, 0,0,8'h00, 2'b11,1, 0,0,0,8'h00, 2'b00,0,0,0));

    do_reset();
    @(negedge clk);
    check("reset_state", 128'({busy, grant, in_rsp, out_req.tvalid, frames, oversize}), 128'(0));
    @(posedge clk);
    #1;

    foreach (tbl[n]) begin
      in_req[0].tvalid = tbl[n].v0;
      in_req[0].t      = mkbeat(tbl[n].d0, tbl[n].l0);
      in_req[1].tvalid = tbl[n].v1;
      in_req[1].t      = mkbeat(tbl[n].d1, tbl[n].l1);
      en               = tbl[n].en;
      out_rsp.tready   = tbl[n].rdy;
      @(negedge clk);
      act  = {out_req.tvalid, out_req.tvalid & out_req.t.last, out_req.tvalid & out_req.t.user[0],
              out_req.tvalid ? out_req.t.data[7:0] : 8'h00, grant, busy, in_rsp[0].tready,
              in_rsp[1].tready};
      expv = {tbl[n].ov, tbl[n].ol, tbl[n].ou, tbl[n].od, tbl[n].g, tbl[n].busy,
              tbl[n].r0, tbl[n].r1};
      checks++;
      if (act !== expv) begin
        errors++;
        $display("FAIL vec%0d actual=%0h expected=%0h", n, act, expv);
      end
      @(posedge clk);
      #1;
    end
    check("table_frames", 128'(frames), 128'(5));
    check("table_oversize", 128'(oversize), 128'(1));

    // Both inputs continuously valid with 2-beat frames: owners alternate.
    do_reset();
    for (int f = 0; f < 2; f++) begin
      add_frame(0, 2, f);
      add_frame(1, 2, f);
    end
    run_traffic(100, 100, 200);
    check("alt_count", 128'(own_log.size()), 128'(4));
    for (int f = 0; f < 4 && f < own_log.size(); f++)
      check($sformatf("alt_owner%0d", f), 128'(own_log[f]), 128'(f % 2));
    check("alt_frames", 128'(frames), 128'(4));

    // Asynchronous reset in the middle of beat 2.
    in_req[0].tvalid = 1'b1;
    in_req[0].t      = mkbeat(8'h60, 1'b0);
    out_rsp.tready   = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_req[0].t = mkbeat(8'h61, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset", 128'({busy, grant, in_rsp, out_req.tvalid, frames, oversize}), 128'(0));
    @(posedge clk); #1;
    rst_n       = 1'b1;
    in_req[0].t = mkbeat(8'h70, 1'b1);
    @(negedge clk);
    check("post_reset_idle", 128'({busy, grant}), 128'(0));
    @(negedge clk);
    check("post_reset_grant", 128'({grant, out_req.tvalid, out_req.t.last, out_req.t.data[7:0]}),
          128'({2'b01, 1'b1, 1'b1, 8'h70}));
    @(posedge clk); #1;
    in_req = '0;
    @(negedge clk);
    check("post_reset_frames", 128'({busy, frames}), 128'(1));
    @(posedge clk); #1;

    // Random traffic, frame lengths crossing the truncation limit.
    do_reset();
    nf  = 0;
    nov = 0;
    for (int f = 0; f < 25; f++) begin
      for (int i = 0; i < NIN; i++) begin
        len = $urandom_range(1, MAXB + 3);
        add_frame(i, len, f);
        nf++;
        if (len > MAXB) nov++;
      end
    end
    run_traffic(70, 70, 8000);
    check("rand_frames", 128'(frames), 128'(nf));
    check("rand_oversize", 128'(oversize), 128'(nov));
    for (int i = 0; i < NIN; i++)
      check($sformatf("rand_leftover%0d", i), 128'(exp_q[i].size()), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
